// File: rtl/mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mode_sequencer_if
// Purpose  : Key inputs and mode/tick outputs of the mode sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mode_sequencer_if #(
    parameter int N_KEYS  = 4,
    parameter int N_MODES = 4,
    parameter int MODE_W  = 2
) ();
    logic                one_second;
    logic [N_KEYS-1:0]   key_pulse;
    logic [N_KEYS-1:0]   key_level;
    logic [MODE_W-1:0]   mode;
    logic [N_MODES-1:0]  mode_led;
    logic                tick;
    logic                select;
    logic                mode_changed;
    logic                reset_out;

    // master: key debouncer / board side; slave: the sequencer itself
    modport master (
        output one_second, key_pulse, key_level,
        input  mode, mode_led, tick, select, mode_changed, reset_out
    );

    modport slave (
        input  one_second, key_pulse, key_level,
        output mode, mode_led, tick, select, mode_changed, reset_out
    );
endinterface
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mode_sequencer
// Purpose  : Mode register stepped by keys, per-mode tick/select, long-press reset.
// Revision : 1.0 - initial release
// ============================================================================
module mode_sequencer #(
    parameter int                   N_KEYS      = 4,
    parameter int                   N_MODES     = 4,
    parameter int                   MODE_W      = 2,
    parameter logic [2*N_MODES-1:0] TICK_SRC    = 8'b10_10_01_01,
    parameter logic [N_MODES-1:0]   SELECT_MAP  = 4'b0101,
    parameter int                   HOLD_CYCLES = 16,
    parameter int                   RST_LEN     = 4
) (
    input  logic            clk,
    input  logic            rst,
    mode_sequencer_if.slave bus
);

    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_RST_W  = $clog2(RST_LEN + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_RST_W-1:0]  c_RST_LAST  = c_RST_W'(RST_LEN - 1);
    localparam logic [MODE_W-1:0]   c_MODE_LAST = MODE_W'(N_MODES - 1);

    // The long-press "HOLD" phase lives inside RUN as a nonzero hold counter.
    localparam logic [1:0] c_ST_RUN     = 2'd0;
    localparam logic [1:0] c_ST_SWITCH  = 2'd1;
    localparam logic [1:0] c_ST_RSTP    = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    localparam logic [1:0] c_SRC_OFF  = 2'b00;
    localparam logic [1:0] c_SRC_SEC  = 2'b01;
    localparam logic [1:0] c_SRC_CYC  = 2'b10;
    localparam logic [1:0] c_SRC_HALF = 2'b11;

    logic [1:0]          r_state;
    logic [MODE_W-1:0]   r_mode;
    logic                r_paused;
    logic                r_div2;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_RST_W-1:0]  r_rst_cnt;
    logic                r_tick;
    logic                r_select;
    logic                r_mode_changed;
    logic                r_reset_out;

    logic [1:0]          w_state_nxt;
    logic [MODE_W-1:0]   w_mode_nxt;
    logic                w_paused_nxt;
    logic                w_div2_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_RST_W-1:0]  w_rst_cnt_nxt;
    logic                w_tick_nxt;
    logic                w_changed_nxt;
    logic                w_reset_out_nxt;

    logic                w_all_held;
    logic                w_step_up;
    logic                w_step_dn;
    logic [1:0]          w_src;

    assign w_all_held = &bus.key_level;
    assign w_step_up  = bus.key_pulse[0] & ~bus.key_pulse[1];
    assign w_step_dn  = bus.key_pulse[1] & ~bus.key_pulse[0];
    assign w_src      = TICK_SRC[{r_mode, 1'b0} +: 2];

    generate
        if (N_KEYS > 3) begin : g_extra_keys
            logic w_unused_keys;
            assign w_unused_keys = ^bus.key_pulse[N_KEYS-1:3];
        end
    endgenerate

    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_paused_nxt    = r_paused;
        w_div2_nxt      = r_div2;
        w_hold_nxt      = '0;
        w_rst_cnt_nxt   = '0;
        w_tick_nxt      = 1'b0;
        w_changed_nxt   = 1'b0;
        w_reset_out_nxt = 1'b0;

        case (r_state)
            c_ST_RUN: begin
                if (w_all_held && (r_hold_cnt == c_HOLD_LAST)) begin
                    w_state_nxt     = c_ST_RSTP;
                    w_mode_nxt      = '0;
                    w_paused_nxt    = 1'b0;
                    w_div2_nxt      = 1'b0;
                    w_changed_nxt   = (r_mode != '0);
                    w_reset_out_nxt = 1'b1;
                end else begin
                    if (w_all_held) begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                    if (bus.key_pulse[2]) begin
                        w_paused_nxt = ~r_paused;
                    end
                    if (w_step_up || w_step_dn) begin
                        if (w_step_up) begin
                            w_mode_nxt = (r_mode == c_MODE_LAST) ? '0 : r_mode + 1'b1;
                        end else begin
                            w_mode_nxt = (r_mode == '0) ? c_MODE_LAST : r_mode - 1'b1;
                        end
                        w_changed_nxt = 1'b1;
                        w_state_nxt   = c_ST_SWITCH;
                    end else if (!r_paused) begin
                        case (w_src)
                            c_SRC_OFF:  w_tick_nxt = 1'b0;
                            c_SRC_SEC:  w_tick_nxt = bus.one_second;
                            c_SRC_CYC:  w_tick_nxt = 1'b1;
                            c_SRC_HALF: begin
                                // Tick on the pulse that returns the divider to 0.
                                w_tick_nxt = bus.one_second & r_div2;
                                if (bus.one_second) begin
                                    w_div2_nxt = ~r_div2;
                                end
                            end
                            default:    w_tick_nxt = 1'b0;
                        endcase
                    end
                end
            end
            c_ST_SWITCH: begin
                w_div2_nxt  = 1'b0;
                w_state_nxt = c_ST_RUN;
            end
            c_ST_RSTP: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_RELEASE;
                end else begin
                    w_rst_cnt_nxt   = r_rst_cnt + 1'b1;
                    w_reset_out_nxt = 1'b1;
                end
            end
            c_ST_RELEASE: begin
                if (bus.key_level == '0) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_RUN;
            r_mode         <= '0;
            r_paused       <= 1'b0;
            r_div2         <= 1'b0;
            r_hold_cnt     <= '0;
            r_rst_cnt      <= '0;
            r_tick         <= 1'b0;
            r_select       <= SELECT_MAP[0];
            r_mode_changed <= 1'b0;
            r_reset_out    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_mode         <= w_mode_nxt;
            r_paused       <= w_paused_nxt;
            r_div2         <= w_div2_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_rst_cnt      <= w_rst_cnt_nxt;
            r_tick         <= w_tick_nxt;
            r_select       <= SELECT_MAP[w_mode_nxt];
            r_mode_changed <= w_changed_nxt;
            r_reset_out    <= w_reset_out_nxt;
        end
    end

    assign bus.mode         = r_mode;
    assign bus.mode_led     = ~(N_MODES'(1) << r_mode);
    assign bus.tick         = r_tick;
    assign bus.select       = r_select;
    assign bus.mode_changed = r_mode_changed;
    assign bus.reset_out    = r_reset_out;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_sequencer
// Purpose  : Directed self-checking bench for mode_sequencer (default and /2 tick maps).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mode_sequencer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [1:0] exp_mode;

    mode_sequencer_if #(.N_KEYS(4), .N_MODES(4), .MODE_W(2)) ifa ();
    mode_sequencer_if #(.N_KEYS(4), .N_MODES(4), .MODE_W(2)) ifb ();

    mode_sequencer dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    // Mode 0 uses the one_second/2 source in this instance.
    mode_sequencer #(.TICK_SRC(8'b10_10_01_11)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifa.one_second = 1'b0; ifa.key_pulse = '0; ifa.key_level = '0;
        ifb.one_second = 1'b0; ifb.key_pulse = '0; ifb.key_level = '0;
        cyc(); cyc();
        chk("rst_mode",   ifa.mode, 0);
        chk("rst_led",    ifa.mode_led, 4'b1110);
        chk("rst_select", ifa.select, 1);
        chk("rst_tick",   ifa.tick, 0);
        chk("rst_chg",    ifa.mode_changed, 0);
        chk("rst_rout",   ifa.reset_out, 0);
        rst = 1'b0;

        // Mode 0 follows one_second with one cycle of latency.
        for (int i = 0; i < 20; i++) begin
            ifa.one_second = (i % 10 == 9);
            cyc();
            chk("os_tick", ifa.tick, (i % 10 == 9));
        end
        ifa.one_second = 1'b0;

        // Five up-steps; key presses and one_second during SWITCH are ignored.
        for (int k = 0; k < 5; k++) begin
            exp_mode = 2'((k + 1) % 4);
            ifa.key_pulse = 4'b0001;
            cyc();
            chk("up_mode", ifa.mode, exp_mode);
            chk("up_chg",  ifa.mode_changed, 1);
            chk("up_tick", ifa.tick, 0);
            ifa.key_pulse  = 4'b0001;
            ifa.one_second = 1'b1;
            cyc();
            chk("sw_mode", ifa.mode, exp_mode);
            chk("sw_tick", ifa.tick, 0);
            chk("sw_chg",  ifa.mode_changed, 0);
            ifa.key_pulse  = '0;
            ifa.one_second = 1'b0;
            cyc();
        end
        chk("up_led",    ifa.mode_led, 4'b1101);
        chk("up_select", ifa.select, 0);

        ifa.key_pulse = 4'b0011;
        cyc();
        chk("both_mode", ifa.mode, 1);
        chk("both_chg",  ifa.mode_changed, 0);
        ifa.key_pulse = '0;

        ifa.key_pulse = 4'b0001;
        cyc();
        ifa.key_pulse = '0;
        cyc(); cyc();
        chk("m2_mode", ifa.mode, 2);
        chk("m2_tick", ifa.tick, 1);

        // Pause toggling in an every-cycle mode.
        ifa.key_pulse = 4'b0100; cyc(); chk("pause_lat",   ifa.tick, 1);
        ifa.key_pulse = '0;      cyc(); chk("paused_tick", ifa.tick, 0);
        cyc();                          chk("paused_hold", ifa.tick, 0);
        ifa.key_pulse = 4'b0100; cyc(); chk("unpause_lat", ifa.tick, 0);
        ifa.key_pulse = '0;      cyc(); chk("resume_tick", ifa.tick, 1);

        // Down-steps 2 -> 1 -> 0 -> 3.
        for (int k = 0; k < 3; k++) begin
            exp_mode = 2'((5 - k) % 4);
            ifa.key_pulse = 4'b0010;
            cyc();
            chk("dn_mode", ifa.mode, exp_mode);
            chk("dn_chg",  ifa.mode_changed, 1);
            ifa.key_pulse = '0;
            cyc(); cyc();
        end
        chk("m3_led",    ifa.mode_led, 4'b0111);
        chk("m3_select", ifa.select, 0);

        // Long press in mode 3.
        ifa.key_level = 4'b1111;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            chk("hold_rout", ifa.reset_out, 0);
        end
        cyc();
        chk("lp_rout", ifa.reset_out, 1);
        chk("lp_mode", ifa.mode, 0);
        chk("lp_chg",  ifa.mode_changed, 1);
        chk("lp_tick", ifa.tick, 0);
        chk("lp_led",  ifa.mode_led, 4'b1110);
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("rstp_rout", ifa.reset_out, 1);
            chk("rstp_chg",  ifa.mode_changed, 0);
        end
        cyc();
        chk("rstp_end", ifa.reset_out, 0);

        // Keys still held: no retrigger, no tick, presses ignored.
        for (int j = 0; j < 50; j++) begin
            ifa.one_second = (j % 10 == 9);
            ifa.key_pulse  = (j == 20) ? 4'b0001 : 4'b0000;
            cyc();
            chk("rel_rout", ifa.reset_out, 0);
            chk("rel_tick", ifa.tick, 0);
        end
        ifa.one_second = 1'b0;
        ifa.key_pulse  = '0;
        chk("rel_mode", ifa.mode, 0);
        ifa.key_level = '0;
        cyc();
        chk("rel_exit_tick", ifa.tick, 0);
        ifa.one_second = 1'b1;
        cyc();
        chk("resume_os_tick", ifa.tick, 1);
        ifa.one_second = 1'b0;
        cyc();
        chk("resume_os_gap", ifa.tick, 0);

        // A released key restarts the hold count.
        ifa.key_level = 4'b1111;
        for (int j = 0; j < 10; j++) begin
            cyc();
            chk("hold1_rout", ifa.reset_out, 0);
        end
        ifa.key_level = 4'b1110;
        cyc();
        chk("hold_gap_rout", ifa.reset_out, 0);
        ifa.key_level = 4'b1111;
        for (int j = 0; j < 10; j++) begin
            cyc();
            chk("hold_clr_rout", ifa.reset_out, 0);
        end
        ifa.key_level = '0;
        cyc();

        // rst in the middle of a reset_out pulse.
        ifa.key_level = 4'b1111;
        for (int j = 0; j < 16; j++) cyc();
        chk("rst2_rout_on", ifa.reset_out, 1);
        cyc();
        rst = 1'b1;
        ifa.key_level = '0;
        cyc();
        chk("midrst_rout", ifa.reset_out, 0);
        chk("midrst_mode", ifa.mode, 0);
        rst = 1'b0;
        ifa.one_second = 1'b1;
        cyc();
        chk("midrst_run_tick", ifa.tick, 1);
        ifa.one_second = 1'b0;

        // Divide-by-2 source: ticks on even pulses after entry.
        for (int p = 1; p <= 7; p++) begin
            ifb.one_second = 1'b1;
            cyc();
            chk("div2_tick", ifb.tick, (p % 2 == 0));
            ifb.one_second = 1'b0;
            cyc();
            chk("div2_gap", ifb.tick, 0);
        end
        ifb.key_pulse = 4'b0001;
        cyc();
        chk("div2_up_mode", ifb.mode, 1);
        ifb.key_pulse = '0;
        cyc(); cyc();
        ifb.key_pulse = 4'b0010;
        cyc();
        chk("div2_dn_mode", ifb.mode, 0);
        ifb.key_pulse = '0;
        cyc(); cyc();
        for (int p = 1; p <= 2; p++) begin
            ifb.one_second = 1'b1;
            cyc();
            chk("div2_restart", ifb.tick, (p == 2));
            ifb.one_second = 1'b0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
